// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - decode-stage interlock: long-latency scoreboard, MDU occupancy, front-end flush sequencing
//
// Purpose:
//   Decides whether the instruction in decode must be bubbled, whether IF/ID must
//   hold, and whether IF/ID must be squashed after an EX redirect. Destinations of
//   loads and MUL/DIV/REM are tracked until their late writeback lands.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_id_*                decoded instruction: valid, rs1, rs2, rd, rd write enable,
//                         load / MDU class flags
//   i_mdu_done            MDU result accepted into MEM (pulse)
//   i_wb_long_valid/rd    long-latency regfile write this cycle and its destination
//   i_ex_redirect         EX resolved a control transfer (pulse)
//   o_has_hazard          decode must zero its control bundles
//   o_stall_if            hold PC and IF/ID
//   o_flush_if_id         squash IF/ID
//   o_mdu_busy            MDU op in flight
//   o_stall_cycles        saturating count of RAW/structural stall cycles

module pipe_hazard_ctrl #(
  parameter int NREG      = 32,   // at most 32: register fields are 5 bits
  parameter int FLUSH_CYC = 1,    // 1..7
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_rd_wen,
  input  logic             i_id_is_load,
  input  logic             i_id_is_mdu,
  input  logic             i_mdu_done,
  input  logic             i_wb_long_valid,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_ex_redirect,
  output logic             o_has_hazard,
  output logic             o_stall_if,
  output logic             o_flush_if_id,
  output logic             o_mdu_busy,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] FCNT_LOAD  = 3'(FLUSH_CYC - 1);
  localparam bit         LONG_FLUSH = (FLUSH_CYC > 1);

  logic [NREG-1:0]  r_pend;
  logic [NREG-1:0]  w_pend_nxt;
  logic             r_mdu_busy;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_fcnt;
  logic [2:0]       w_fcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rs1_pend;
  logic w_rs2_pend;
  logic w_rd_pend;
  logic w_raw;
  logic w_waw;
  logic w_strc;
  logic w_haz;
  logic w_flush_act;
  logic w_issue;
  logic w_set;

  // Scoreboard lookups. Loops start at 1 so a zero register field never matches,
  // which is how x0 stays immune without separate !=0 terms.
  always_comb begin
    w_rs1_pend = 1'b0;
    w_rs2_pend = 1'b0;
    w_rd_pend  = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (i_id_rs1 == 5'(i)) w_rs1_pend = r_pend[i];
      if (i_id_rs2 == 5'(i)) w_rs2_pend = r_pend[i];
      if (i_id_rd  == 5'(i)) w_rd_pend  = r_pend[i];
    end
  end

  // Hazards come from registered state only: a writeback this cycle does not
  // release a dependent until the next cycle (no bypass into decode).
  assign w_raw       = i_id_valid & (w_rs1_pend | w_rs2_pend);
  assign w_waw       = i_id_valid & i_id_rd_wen & w_rd_pend;
  assign w_strc      = i_id_valid & i_id_is_mdu & r_mdu_busy;
  assign w_haz       = w_raw | w_waw | w_strc;
  assign w_flush_act = (r_state == ST_FLUSH) | i_ex_redirect;

  // A squashed or stalled instruction never reaches the scoreboard.
  assign w_issue = i_id_valid & ~w_haz & ~w_flush_act;
  assign w_set   = w_issue & i_id_rd_wen & (i_id_is_load | i_id_is_mdu);

  assign o_has_hazard   = w_haz | w_flush_act;
  assign o_stall_if     = w_haz & ~w_flush_act;   // redirect wins so PC takes the target
  assign o_flush_if_id  = w_flush_act;
  assign o_mdu_busy     = r_mdu_busy;
  assign o_stall_cycles = r_stall_cnt;

  // Clear on long writeback, then set on issue, so a same-cycle set wins.
  // Writebacks to non-pending registers simply clear an already-clear bit.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 1; i < NREG; i++) begin
      if (i_wb_long_valid && (i_wb_rd == 5'(i))) w_pend_nxt[i] = 1'b0;
      if (w_set && (i_id_rd == 5'(i)))           w_pend_nxt[i] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  // Flush sequencer. The redirect cycle itself is the first flush cycle, so
  // FLUSH covers the remaining FLUSH_CYC-1 cycles; fcnt counts those down.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (i_ex_redirect && LONG_FLUSH) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FCNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (i_ex_redirect) begin
          w_fcnt_nxt = FCNT_LOAD;
        end else if (r_fcnt <= 3'd1) begin
          w_state_nxt = ST_RUN;
          w_fcnt_nxt  = 3'd0;
        end else begin
          w_fcnt_nxt = r_fcnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend      <= '0;
      r_mdu_busy  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      // Done and a new issue in the same cycle hand the unit straight over.
      r_mdu_busy <= (r_mdu_busy & ~i_mdu_done) | (w_issue & i_id_is_mdu);
      if (o_stall_if && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized bench for pipe_hazard_ctrl against a behavioural model

module tb_pipe_hazard_ctrl;

  localparam int     FLUSH_CYC = 3;
  localparam longint CNT_MAX   = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rd_wen, id_is_load, id_is_mdu;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        mdu_done, wb_long_valid, ex_redirect;
  logic        has_hazard, stall_if, flush_if_id, mdu_busy;
  logic [31:0] stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model state: which registers are owed, whether the MDU is occupied, how many
  // more flush cycles follow the current one, and the stall tally.
  bit     m_pend [32];
  bit     m_mdu;
  int     m_fleft;
  longint m_cnt;

  pipe_hazard_ctrl #(.NREG(32), .FLUSH_CYC(FLUSH_CYC), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .i_id_rd_wen(id_rd_wen), .i_id_is_load(id_is_load), .i_id_is_mdu(id_is_mdu),
    .i_mdu_done(mdu_done), .i_wb_long_valid(wb_long_valid), .i_wb_rd(wb_rd),
    .i_ex_redirect(ex_redirect),
    .o_has_hazard(has_hazard), .o_stall_if(stall_if), .o_flush_if_id(flush_if_id),
    .o_mdu_busy(mdu_busy), .o_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_haz();
    bit raw, waw, strc;
    raw  = id_valid && ((id_rs1 != 0 && m_pend[id_rs1]) || (id_rs2 != 0 && m_pend[id_rs2]));
    waw  = id_valid && id_rd_wen && id_rd != 0 && m_pend[id_rd];
    strc = id_valid && id_is_mdu && m_mdu;
    return raw || waw || strc;
  endfunction

  function automatic bit m_flush();
    return (m_fleft > 0) || ex_redirect;
  endfunction

  // Compare every output against the model, away from the clock edge.
  task automatic cmp_cycle();
    #1;
    chk("has_hazard",   longint'(has_hazard),   longint'(m_haz() || m_flush()));
    chk("stall_if",     longint'(stall_if),     longint'(m_haz() && !m_flush()));
    chk("flush_if_id",  longint'(flush_if_id),  longint'(m_flush()));
    chk("mdu_busy",     longint'(mdu_busy),     longint'(m_mdu));
    chk("stall_cycles", longint'(stall_cycles), m_cnt);
  endtask

  // Advance model and DUT by one clock.
  task automatic tick();
    bit     n_pend [32];
    bit     n_mdu, issue;
    int     n_fleft;
    longint n_cnt;
    n_pend  = m_pend;
    n_mdu   = m_mdu;
    n_fleft = m_fleft;
    n_cnt   = m_cnt;
    if (rst) begin
      foreach (n_pend[i]) n_pend[i] = 1'b0;
      n_mdu = 1'b0; n_fleft = 0; n_cnt = 0;
    end else begin
      issue = id_valid && !m_haz() && !m_flush();
      if (wb_long_valid && wb_rd != 0) n_pend[wb_rd] = 1'b0;
      if (issue && id_rd_wen && id_rd != 0 && (id_is_load || id_is_mdu)) n_pend[id_rd] = 1'b1;
      n_mdu = (m_mdu && !mdu_done) || (issue && id_is_mdu);
      if (ex_redirect) n_fleft = FLUSH_CYC - 1;
      else if (m_fleft > 0) n_fleft = m_fleft - 1;
      if (m_haz() && !m_flush() && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
    end
    @(posedge clk);
    m_pend = n_pend; m_mdu = n_mdu; m_fleft = n_fleft; m_cnt = n_cnt;
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    cmp_cycle();
    tick();
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_wen = 0;
    id_is_load = 0; id_is_mdu = 0; mdu_done = 0; wb_long_valid = 0; wb_rd = 0;
    ex_redirect = 0; rst = 0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic mdu);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd_wen = wen; id_is_load = ld; id_is_mdu = mdu;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Reset state.
    cmp_cycle();
    chk("lit_rst_haz", has_hazard, 0);
    chk("lit_rst_stall", stall_if, 0);
    chk("lit_rst_flush", flush_if_id, 0);
    chk("lit_rst_busy", mdu_busy, 0);
    chk("lit_rst_cnt", stall_cycles, 0);
    tick();

    // Load-use: load x5, then add x6,x5,x1 waits through the writeback cycle.
    instr(0, 0, 5, 1, 1, 0);
    step();
    instr(5, 1, 6, 1, 0, 0);
    repeat (3) begin
      cmp_cycle(); chk("lit_lu_stall", stall_if, 1); tick();
    end
    wb_long_valid = 1; wb_rd = 5;
    cmp_cycle(); chk("lit_lu_wb_cycle", has_hazard, 1); tick();
    wb_long_valid = 0;
    cmp_cycle(); chk("lit_lu_release", has_hazard, 0); chk("lit_lu_cnt", stall_cycles, 4); tick();

    // x0 immunity.
    instr(0, 0, 0, 1, 1, 0);
    step();
    instr(0, 0, 0, 1, 0, 0);
    cmp_cycle(); chk("lit_x0", has_hazard, 0); tick();

    // MDU structural hazard.
    instr(1, 2, 7, 1, 0, 1);
    step();
    instr(1, 2, 8, 1, 0, 1);
    cmp_cycle(); chk("lit_strc_haz", stall_if, 1); chk("lit_strc_busy", mdu_busy, 1); tick();
    mdu_done = 1;
    cmp_cycle(); chk("lit_strc_done_cycle", stall_if, 1); tick();
    mdu_done = 0;
    cmp_cycle(); chk("lit_mdu_issue", has_hazard, 0); tick();
    idle();
    cmp_cycle(); chk("lit_mdu_still_busy", mdu_busy, 1); tick();
    mdu_done = 1; wb_long_valid = 1; wb_rd = 7;
    step();
    mdu_done = 0; wb_rd = 8;
    step();
    idle();

    // Spurious writeback of x9 collides with a new load x9: set wins.
    instr(0, 0, 9, 1, 1, 0);
    wb_long_valid = 1; wb_rd = 9;
    step();
    wb_long_valid = 0;
    instr(9, 0, 10, 1, 0, 0);
    cmp_cycle(); chk("lit_collision", has_hazard, 1); tick();
    wb_long_valid = 1; wb_rd = 9;
    step();
    wb_long_valid = 0;
    step();
    idle();

    // Redirect over a RAW stall; squashed load x4 must not enter the scoreboard.
    instr(0, 0, 10, 1, 1, 0);
    step();
    instr(10, 0, 4, 1, 1, 0);
    cmp_cycle(); chk("lit_pre_redir_stall", stall_if, 1); tick();
    ex_redirect = 1;
    cmp_cycle();
    chk("lit_redir_flush", flush_if_id, 1);
    chk("lit_redir_stall", stall_if, 0);
    chk("lit_redir_haz", has_hazard, 1);
    tick();
    idle();
    cmp_cycle(); chk("lit_flush_c1", flush_if_id, 1); tick();
    cmp_cycle(); chk("lit_flush_c2", flush_if_id, 1); tick();
    cmp_cycle(); chk("lit_flush_c3", flush_if_id, 0); tick();
    wb_long_valid = 1; wb_rd = 10;
    step();
    idle();
    instr(4, 0, 11, 1, 0, 0);
    cmp_cycle(); chk("lit_x4_not_pend", has_hazard, 0); tick();
    idle();

    // Second redirect during flush extends it.
    ex_redirect = 1; step();
    ex_redirect = 0; step();
    ex_redirect = 1; step();
    ex_redirect = 0; step();
    cmp_cycle(); chk("lit_ext_c4", flush_if_id, 1); tick();
    cmp_cycle(); chk("lit_ext_c5", flush_if_id, 0); tick();

    // Reset mid-flight.
    instr(0, 0, 3, 1, 1, 0); step();
    instr(0, 0, 5, 1, 1, 0); step();
    instr(0, 0, 12, 1, 0, 1); step();
    idle();
    cmp_cycle(); chk("lit_pre_rst_busy", mdu_busy, 1); tick();
    rst = 1; step(); rst = 0;
    cmp_cycle();
    chk("lit_mid_rst_haz", has_hazard, 0);
    chk("lit_mid_rst_stall", stall_if, 0);
    chk("lit_mid_rst_flush", flush_if_id, 0);
    chk("lit_mid_rst_busy", mdu_busy, 0);
    chk("lit_mid_rst_cnt", stall_cycles, 0);
    tick();
    instr(3, 5, 13, 1, 0, 1);
    cmp_cycle(); chk("lit_post_rst_issue", has_hazard, 0); tick();
    idle();

    // Randomized traffic over a small register window to provoke collisions.
    for (int k = 0; k < 3000; k++) begin
      id_valid      = ($urandom_range(0, 9) < 7);
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_rd         = 5'($urandom_range(0, 7));
      id_rd_wen     = ($urandom_range(0, 9) < 8);
      id_is_load    = ($urandom_range(0, 9) < 3);
      id_is_mdu     = !id_is_load && ($urandom_range(0, 9) < 2);
      mdu_done      = ($urandom_range(0, 3) == 0);
      wb_long_valid = ($urandom_range(0, 9) < 3);
      wb_rd         = 5'($urandom_range(0, 7));
      ex_redirect   = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name:
pipe_hazard_ctrl

Overview:
- Pipeline interlock controller between the decode stage and the EX/MEM/WB stages.
- Keeps a scoreboard of destination registers owed by long-latency ops (loads, MUL/DIV/REM), tracks single-entry MDU occupancy, and sequences front-end flushes on EX redirects.
- Produces the has_hazard bubble that decode uses to zero its control bundles, plus the IF/ID stall and flush strobes.

Parameters:
NREG, 32, architectural register count; x0 is never tracked.
FLUSH_CYC, 1, cycles flush_if_id stays asserted per redirect (1..7).
CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
id_valid  input  1  decode holds a real instruction
id_rs1  input  5  decode rs1 (already 0 when unused)
id_rs2  input  5  decode rs2 (already 0 when unused)
id_rd  input  5  decode rd
id_rd_wen  input  1  decoded instruction writes rd
id_is_load  input  1  decoded instruction is a load
id_is_mdu  input  1  decoded instruction is MUL/DIV/REM (incl. W forms)
mdu_done  input  1  MDU result accepted into MEM this cycle (pulse)
wb_long_valid  input  1  long-latency result is written to the regfile this cycle
wb_rd  input  5  destination of that write
ex_redirect  input  1  EX resolved taken branch/jump/trap/mret/fence.i (pulse)
has_hazard  output  1  bubble: decode zeroes its ctrl_wb/mem/ex
stall_if  output  1  hold PC and IF/ID register
flush_if_id  output  1  squash IF/ID contents
mdu_busy  output  1  MDU op in flight
stall_cycles  output  CNT_W  saturating count of RAW/structural stall cycles

Behaviour:
- State: pend[NREG-1:1] bits, mdu_busy_q, FSM {RUN, FLUSH}, flush counter fcnt (3 bits), stall_cycles.
- Reset: pend all 0, mdu_busy_q 0, FSM=RUN, fcnt 0, stall_cycles 0.
- Reset outputs: has_hazard 0, stall_if 0, flush_if_id 0, mdu_busy 0, stall_cycles 0.
- rst asserted mid-operation discards all pending entries immediately. No drain.
- Combinational hazard terms, from registered state only:
  - raw = id_valid & ((id_rs1!=0 & pend[id_rs1]) | (id_rs2!=0 & pend[id_rs2])).
  - waw = id_valid & id_rd_wen & id_rd!=0 & pend[id_rd].
  - strc = id_valid & id_is_mdu & mdu_busy_q.
  - haz = raw | waw | strc.
- flush_act = (FSM==FLUSH) | ex_redirect.
- Outputs:
  - has_hazard = haz | flush_act.
  - stall_if = haz & ~flush_act.
  - flush_if_id = flush_act.
  - mdu_busy = mdu_busy_q.
- issue = id_valid & ~haz & ~flush_act. A squashed or stalled instruction never touches the scoreboard.
- Scoreboard update, next cycle:
  - If wb_long_valid & wb_rd!=0: clear pend[wb_rd].
  - If issue & id_rd_wen & id_rd!=0 & (id_is_load|id_is_mdu): set pend[id_rd].
  - Same register set and cleared in the same cycle: set wins.
- Release latency: a hazard on register r drops the cycle after wb_long_valid for r, since the regfile write lands at that edge. No same-cycle bypass.
- MDU tracking, next cycle: mdu_busy_q <= (mdu_busy_q & ~mdu_done) | (issue & id_is_mdu). Issue and done together leave it at 1.
- FSM transitions:
  - RUN: on ex_redirect, go to FLUSH with fcnt=FLUSH_CYC-1 if FLUSH_CYC>1. If FLUSH_CYC=1, stay in RUN; flush is that single cycle.
  - FLUSH: fcnt decrements each cycle; at 0 return to RUN.
  - ex_redirect while in FLUSH reloads fcnt=FLUSH_CYC-1.
- Redirect priority: redirect beats a pending RAW/structural stall. stall_if=0 so the PC takes the redirect target; the ID instruction is bubbled and its scoreboard effect dropped.
- stall_cycles increments when stall_if=1 and saturates at all-ones.
- Undefined input: wb_long_valid for a register with pend=0 is ignored (no underflow).

Test Plan:
- Load-use: issue load x5, next cycle add x6,x5,x1 -> has_hazard=1 and stall_if=1 until wb_long_valid with wb_rd=5; drop exactly one cycle later; stall_cycles equals stalled cycles.
- x0 immunity: issue load x0, then use x0 -> no hazard; pend unchanged.
- MDU structural: div x7 issued, then mul x8 while mdu_done=0 -> stall on strc only; mdu_done pulse releases next cycle; mul issues and mdu_busy stays 1.
- Set/clear collision: wb_long_valid for x9 in the same cycle a new load x9 issues -> pend[9]=1 next cycle; dependent instruction still stalls.
- Redirect over stall: raw stall active and ex_redirect pulses -> flush_if_id=1, stall_if=0, has_hazard=1; squashed load x4 does not set pend[4]. With FLUSH_CYC=3, flush lasts 3 cycles; a second redirect in cycle 2 extends it to cycle 4 (2+3-1).
- Reset mid-flight: pend{x3,x5}=1 and mdu_busy=1, assert rst one cycle -> next cycle all outputs 0; a dependent instruction issues without hazard.
